// File: rtl/patch_scheduler.sv
// patch_scheduler: walks an image buffer patch by patch and streams each pixel
// out over a valid/ready handshake, tagged with its patch and position index.
// One beat costs three cycles: address the buffer, capture the pixel, emit it.
module patch_scheduler #(
   parameter int PIXEL_WIDTH = 24,
   parameter int IMG_WIDTH   = 64,
   parameter int IMG_HEIGHT  = 64,
   parameter int PATCH_SIZE  = 16,
   localparam int ROW_W       = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1,
   localparam int COL_W       = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1,
   localparam int NUM_PATCHES = (IMG_WIDTH / PATCH_SIZE) * (IMG_HEIGHT / PATCH_SIZE),
   localparam int PIDX_W      = (NUM_PATCHES > 1) ? $clog2(NUM_PATCHES) : 1,
   localparam int POS_W       = (PATCH_SIZE > 1) ? $clog2(PATCH_SIZE * PATCH_SIZE) : 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   abort,
   output logic                   busy,
   output logic                   done,
   output logic                   rd_en,
   output logic [ROW_W-1:0]       rd_row,
   output logic [COL_W-1:0]       rd_col,
   input  logic [PIXEL_WIDTH-1:0] rd_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [PIXEL_WIDTH-1:0] out_pixel,
   output logic [PIDX_W-1:0]      out_patch_idx,
   output logic [POS_W-1:0]       out_pos_idx,
   output logic                   out_patch_last,
   output logic                   out_frame_last
);

   localparam int PATCH_COLS = IMG_WIDTH / PATCH_SIZE;
   localparam int PATCH_ROWS = IMG_HEIGHT / PATCH_SIZE;
   localparam int PR_W = (PATCH_ROWS > 1) ? $clog2(PATCH_ROWS) : 1;
   localparam int PC_W = (PATCH_COLS > 1) ? $clog2(PATCH_COLS) : 1;
   localparam int PS_W = (PATCH_SIZE > 1) ? $clog2(PATCH_SIZE) : 1;

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] READ    = 3'd1;
   localparam logic [2:0] CAPTURE = 3'd2;
   localparam logic [2:0] EMIT    = 3'd3;
   localparam logic [2:0] DONE    = 3'd4;

   logic [2:0]      state;
   logic [PR_W-1:0] patch_row;
   logic [PC_W-1:0] patch_col;
   logic [PS_W-1:0] pos_row;
   logic [PS_W-1:0] pos_col;

   logic pos_col_end, pos_row_end, patch_col_end, patch_row_end;
   logic handshake, kill;

   assign pos_col_end   = (pos_col == PS_W'(PATCH_SIZE - 1));
   assign pos_row_end   = (pos_row == PS_W'(PATCH_SIZE - 1));
   assign patch_col_end = (patch_col == PC_W'(PATCH_COLS - 1));
   assign patch_row_end = (patch_row == PR_W'(PATCH_ROWS - 1));

   assign busy      = (state != IDLE);
   assign done      = (state == DONE);
   assign rd_en     = (state == READ);
   assign out_valid = (state == EMIT);
   assign handshake = out_valid && out_ready;
   // abort only bites while a frame is in flight
   assign kill      = abort && busy;

   assign rd_row = ROW_W'(patch_row) * ROW_W'(PATCH_SIZE) + ROW_W'(pos_row);
   assign rd_col = COL_W'(patch_col) * COL_W'(PATCH_SIZE) + COL_W'(pos_col);

   assign out_patch_idx  = PIDX_W'(patch_row) * PIDX_W'(PATCH_COLS) + PIDX_W'(patch_col);
   assign out_pos_idx    = POS_W'(pos_row) * POS_W'(PATCH_SIZE) + POS_W'(pos_col);
   assign out_patch_last = out_valid && pos_col_end && pos_row_end;
   assign out_frame_last = out_patch_last && patch_col_end && patch_row_end;

   // frame sequencing; abort outranks a handshake in the same cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else if (kill) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE:    if (start) state <= READ;
            READ:    state <= CAPTURE;
            CAPTURE: state <= EMIT;
            EMIT:    if (out_ready) state <= out_frame_last ? DONE : READ;
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // position counters: pos_col -> pos_row -> patch_col -> patch_row
   always_ff @(posedge clk) begin
      if (reset || kill || (handshake && out_frame_last)) begin
         patch_row <= '0;
         patch_col <= '0;
         pos_row   <= '0;
         pos_col   <= '0;
      end else if (handshake) begin
         if (!pos_col_end) begin
            pos_col <= pos_col + 1'b1;
         end else begin
            pos_col <= '0;
            if (!pos_row_end) begin
               pos_row <= pos_row + 1'b1;
            end else begin
               pos_row <= '0;
               if (!patch_col_end) begin
                  patch_col <= patch_col + 1'b1;
               end else begin
                  patch_col <= '0;
                  patch_row <= patch_row + 1'b1;
               end
            end
         end
      end
   end

   // pixel arrives the cycle after rd_en, i.e. while in CAPTURE
   always_ff @(posedge clk) begin
      if (reset) out_pixel <= '0;
      else if (state == CAPTURE) out_pixel <= rd_data;
   end

endmodule

// File: tb/tb_patch_scheduler.sv
// Bench for patch_scheduler: a behavioural buffer returns {row,col} pixels and a
// beat-number model predicts address, pixel and tags of every streamed beat.
module tb_patch_scheduler;

   localparam int PW = 24, W = 64, H = 64, PS = 16;
   localparam int BEATS = W * H;

   logic          clk = 1'b0;
   logic          reset = 1'b1, start = 1'b0, abort = 1'b0, out_ready = 1'b0;
   logic          busy, done, rd_en, out_valid, out_patch_last, out_frame_last;
   logic [5:0]    rd_row, rd_col;
   logic [PW-1:0] rd_data = '0, out_pixel;
   logic [3:0]    out_patch_idx;
   logic [7:0]    out_pos_idx;

   int vectors = 0;
   int errors  = 0;

   patch_scheduler #(.PIXEL_WIDTH(PW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .PATCH_SIZE(PS)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .busy(busy), .done(done),
      .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
      .out_patch_idx(out_patch_idx), .out_pos_idx(out_pos_idx),
      .out_patch_last(out_patch_last), .out_frame_last(out_frame_last)
   );

   always #5 clk = ~clk;

   // image buffer: one-cycle read latency, junk on cycles with no read
   always @(posedge clk)
      rd_data <= rd_en ? (PW'(rd_row) * PW'(256) + PW'(rd_col)) : PW'($urandom);

   // beat n of a frame -> source pixel coordinates and its tags
   function automatic void model(input int n, output int row, output int col,
                                 output int patch, output int pos);
      patch = n / (PS * PS);
      pos   = n % (PS * PS);
      row   = (patch / (W / PS)) * PS + pos / PS;
      col   = (patch % (W / PS)) * PS + pos % PS;
   endfunction

   task automatic test_reset();
      reset = 1'b1; start = 1'b1; abort = 1'b1;
      repeat (2) @(negedge clk);
      vectors++;
      if ({busy, done, rd_en, out_valid, out_patch_last, out_frame_last} !== 6'b0 ||
          out_pixel !== '0 || out_patch_idx !== '0 || out_pos_idx !== '0 ||
          rd_row !== '0 || rd_col !== '0) begin
         errors++;
         $display("FAIL reset_state: busy=%b done=%b rd_en=%b valid=%b pix=%h pidx=%0d pos=%0d row=%0d col=%0d, want all 0",
                  busy, done, rd_en, out_valid, out_pixel, out_patch_idx, out_pos_idx, rd_row, rd_col);
      end
      reset = 1'b0; start = 1'b0; abort = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_abort_idle();
      abort = 1'b1;
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || rd_en !== 1'b0) begin
         errors++;
         $display("FAIL abort_idle: busy=%b rd_en=%b, want 0 0", busy, rd_en);
      end
      abort = 1'b0;
   endtask

   task automatic test_full_frame();
      int n = 0, plast = 0, done_cyc = 0, last_hs = 0, row, col, patch, pos;
      out_ready = 1'b1; start = 1'b1;
      for (int c = 1; c <= 13000 && done_cyc == 0; c++) begin
         @(negedge clk);
         start = 1'b0;
         model(n, row, col, patch, pos);
         if (rd_en) begin
            vectors++;
            if (out_valid !== 1'b0 || rd_row !== 6'(row) || rd_col !== 6'(col)) begin
               errors++;
               $display("FAIL full_rd beat %0d: row=%0d col=%0d valid=%b, want %0d %0d 0",
                        n, rd_row, rd_col, out_valid, row, col);
            end
         end
         if (out_valid) begin
            vectors++;
            if (out_pixel !== PW'(row * 256 + col) || out_patch_idx !== 4'(patch) ||
                out_pos_idx !== 8'(pos) || out_patch_last !== (pos == PS * PS - 1) ||
                out_frame_last !== (n == BEATS - 1)) begin
               errors++;
               $display("FAIL full_beat %0d: pix=%h pidx=%0d pos=%0d pl=%b fl=%b, want %h %0d %0d %b %b",
                        n, out_pixel, out_patch_idx, out_pos_idx, out_patch_last, out_frame_last,
                        PW'(row * 256 + col), patch, pos, pos == PS * PS - 1, n == BEATS - 1);
            end
            if (out_patch_last) plast++;
            n++;
            last_hs = c;
         end
         if (done) done_cyc = c;
      end
      vectors++;
      if (n !== BEATS || plast !== 16) begin
         errors++;
         $display("FAIL full_counts: beats=%0d patch_last=%0d, want %0d 16", n, plast, BEATS);
      end
      vectors++;
      if (done_cyc + 1 !== 12290 || done_cyc !== last_hs + 1) begin
         errors++;
         $display("FAIL full_timing: start-to-done=%0d hs-to-done=%0d, want 12290 1",
                  done_cyc + 1, done_cyc - last_hs);
      end
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL full_idle: busy=%b done=%b, want 0 0", busy, done);
      end
   endtask

   task automatic test_backpressure();
      int n = 0, held = 0, row, col, patch, pos;
      bit stalled = 0;
      logic [PW-1:0] pix = '0;
      logic [3:0] pidx = '0;
      logic [7:0] pidx_pos = '0;
      start = 1'b1; out_ready = 1'b0;
      for (int c = 1; c <= 5000 && n < 300; c++) begin
         @(negedge clk);
         start = 1'b0;
         model(n, row, col, patch, pos);
         if (rd_en) begin
            vectors++;
            if (stalled || out_valid !== 1'b0 || rd_row !== 6'(row) || rd_col !== 6'(col)) begin
               errors++;
               $display("FAIL bp_rd beat %0d: row=%0d col=%0d valid=%b stalled=%0d, want %0d %0d 0 0",
                        n, rd_row, rd_col, out_valid, stalled, row, col);
            end
         end
         if (stalled) begin
            vectors++;
            if (out_valid !== 1'b1 || out_pixel !== pix || out_patch_idx !== pidx || out_pos_idx !== pidx_pos) begin
               errors++;
               $display("FAIL bp_hold beat %0d: valid=%b pix=%h pidx=%0d pos=%0d, want 1 %h %0d %0d",
                        n, out_valid, out_pixel, out_patch_idx, out_pos_idx, pix, pidx, pidx_pos);
            end
         end
         if (out_valid) begin
            vectors++;
            if (out_pixel !== PW'(row * 256 + col) || out_patch_idx !== 4'(patch) || out_pos_idx !== 8'(pos)) begin
               errors++;
               $display("FAIL bp_beat %0d: pix=%h pidx=%0d pos=%0d, want %h %0d %0d",
                        n, out_pixel, out_patch_idx, out_pos_idx, PW'(row * 256 + col), patch, pos);
            end
         end
         if (n == 150 && held < 10) begin
            out_ready = 1'b0;
            if (out_valid) held++;
         end else begin
            out_ready = ($urandom_range(0, 2) != 0);
         end
         stalled = out_valid && !out_ready;
         if (out_valid && out_ready) n++;
         pix = out_pixel; pidx = out_patch_idx; pidx_pos = out_pos_idx;
      end
      vectors++;
      if (n !== 300 || held !== 10) begin
         errors++;
         $display("FAIL bp_progress: beats=%0d held=%0d, want 300 10", n, held);
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      vectors++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_abort: busy=%b valid=%b, want 0 0", busy, out_valid);
      end
   endtask

   task automatic test_abort();
      int n = 0, row, col, patch, pos, dones = 0;
      bit hit = 0;
      start = 1'b1; out_ready = 1'b1;
      for (int c = 1; c <= 1000 && !hit; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (out_valid) begin
            if (n == 100) begin
               model(n, row, col, patch, pos);
               vectors++;
               if (out_patch_idx !== 4'(patch) || out_pos_idx !== 8'(pos)) begin
                  errors++;
                  $display("FAIL abort_at: pidx=%0d pos=%0d, want %0d %0d", out_patch_idx, out_pos_idx, patch, pos);
               end
               abort = 1'b1;
               hit = 1;
            end else begin
               n++;
            end
         end
      end
      @(negedge clk);
      abort = 1'b0;
      vectors++;
      if (!hit || busy !== 1'b0 || out_valid !== 1'b0 || rd_en !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL abort_idle_next: reached=%0d busy=%b valid=%b rd_en=%b done=%b, want 1 0 0 0 0",
                  hit, busy, out_valid, rd_en, done);
      end
      repeat (5) begin
         @(negedge clk);
         if (done) dones++;
      end
      vectors++;
      if (dones !== 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_no_done: done pulses=%0d busy=%b, want 0 0", dones, busy);
      end
      // abort alongside start in IDLE must not block the start
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      vectors++;
      if (rd_en !== 1'b1 || rd_row !== 6'd0 || rd_col !== 6'd0) begin
         errors++;
         $display("FAIL abort_restart_rd: rd_en=%b row=%0d col=%0d, want 1 0 0", rd_en, rd_row, rd_col);
      end
      repeat (2) @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || out_patch_idx !== 4'd0 || out_pos_idx !== 8'd0 || out_pixel !== '0) begin
         errors++;
         $display("FAIL abort_restart_beat: valid=%b pidx=%0d pos=%0d pix=%h, want 1 0 0 0",
                  out_valid, out_patch_idx, out_pos_idx, out_pixel);
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
   endtask

   task automatic test_start_busy();
      int n = 0, dones = 0, row, col, patch, pos;
      bit fin = 0;
      start = 1'b1; out_ready = 1'b1;
      for (int c = 1; c <= 13000 && !fin; c++) begin
         @(negedge clk);
         start = (n < BEATS - 4) ? 1'($urandom_range(0, 1)) : 1'b0;
         if (out_valid) begin
            model(n, row, col, patch, pos);
            vectors++;
            if (out_patch_idx !== 4'(patch) || out_pos_idx !== 8'(pos) || out_pixel !== PW'(row * 256 + col)) begin
               errors++;
               $display("FAIL sb_beat %0d: pidx=%0d pos=%0d pix=%h, want %0d %0d %h",
                        n, out_patch_idx, out_pos_idx, out_pixel, patch, pos, PW'(row * 256 + col));
            end
            n++;
         end
         if (done) begin
            dones++;
            fin = 1;
         end
      end
      start = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (done || busy) dones++;
      end
      vectors++;
      if (n !== BEATS || dones !== 1) begin
         errors++;
         $display("FAIL start_busy: beats=%0d frame events=%0d, want %0d 1", n, dones, BEATS);
      end
   endtask

   task automatic test_reset_mid();
      int dones = 0;
      bit hit = 0;
      start = 1'b1; out_ready = 1'b0;
      for (int c = 1; c <= 50 && !hit; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (out_valid) hit = 1;
      end
      reset = 1'b1; start = 1'b1; abort = 1'b1;
      @(negedge clk);
      vectors++;
      if (!hit || {busy, done, rd_en, out_valid, out_patch_last, out_frame_last} !== 6'b0 ||
          out_pixel !== '0 || out_patch_idx !== '0 || out_pos_idx !== '0 ||
          rd_row !== '0 || rd_col !== '0) begin
         errors++;
         $display("FAIL reset_mid: reached=%0d busy=%b valid=%b rd_en=%b pix=%h pidx=%0d pos=%0d, want 1 0 0 0 0 0 0",
                  hit, busy, out_valid, rd_en, out_pixel, out_patch_idx, out_pos_idx);
      end
      reset = 1'b0; start = 1'b0; abort = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (done || busy) dones++;
      end
      vectors++;
      if (dones !== 0) begin
         errors++;
         $display("FAIL reset_mid_quiet: busy/done cycles=%0d, want 0", dones);
      end
   endtask

   initial begin
      test_reset();
      test_abort_idle();
      test_full_frame();
      test_backpressure();
      test_abort();
      test_start_busy();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
